texture_quad_buffer: RTL and testbench

Double-buffered texture memory that serves the texel quad requests of the texture mapping unit and is filled from the command stream. Every cycle it takes four independent texel word addresses and returns four texels one clock later. While the front page is read, a new texture streams into the back page. A swap request exchanges the pages once any in-flight upload has completed.

---
 rtl/texture_quad_buffer.sv | 183 ++++++++++++++++++
 tb/tb_texture_quad_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/texture_quad_buffer.sv
// Double-buffered texture store: four replicated memories serve a texel quad per cycle
// from the front page while an AXI-Stream upload fills the back page.
module texture_quad_buffer #(
   parameter int STREAM_WIDTH = 64,
   parameter int PIXEL_WIDTH  = 32,
   parameter int ADDR_WIDTH   = 17
) (
   input  logic                    aclk,
   input  logic                    resetn,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
   input  logic                    swapTexture,
   output logic                    swapPending,
   output logic                    loadBusy,
   output logic                    frontPage,
   input  logic [ADDR_WIDTH-1:0]   texelAddr00,
   input  logic [ADDR_WIDTH-1:0]   texelAddr01,
   input  logic [ADDR_WIDTH-1:0]   texelAddr10,
   input  logic [ADDR_WIDTH-1:0]   texelAddr11,
   output logic [PIXEL_WIDTH-1:0]  texelOutput00,
   output logic [PIXEL_WIDTH-1:0]  texelOutput01,
   output logic [PIXEL_WIDTH-1:0]  texelOutput10,
   output logic [PIXEL_WIDTH-1:0]  texelOutput11
);

   localparam int TEXELS_PER_BEAT = STREAM_WIDTH / PIXEL_WIDTH;
   localparam int DEPTH           = 2 ** (ADDR_WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SWAP
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic                    front_page_q, front_page_d;
   logic                    swap_pending_q, swap_pending_d;
   logic                    tready_q, tready_d;
   logic                    load_busy_q, load_busy_d;
   logic                    beat_accept;

   logic [ADDR_WIDTH-1:0]   rd_addr [4];
   logic [PIXEL_WIDTH-1:0]  rd_data [4];
   logic [PIXEL_WIDTH-1:0]  texel_d [4];
   logic [PIXEL_WIDTH-1:0]  texel_q [4];

   assign beat_accept = s_axis_tvalid & tready_q;

   always_comb begin
      state_d        = state_q;
      wr_addr_d      = wr_addr_q;
      front_page_d   = front_page_q;
      swap_pending_d = swap_pending_q;

      case (state_q)
         ST_IDLE: begin
            if (beat_accept) begin
               if (s_axis_tlast) begin
                  wr_addr_d = '0;
                  if (swap_pending_q) begin
                     state_d        = ST_SWAP;
                     swap_pending_d = 1'b0;
                  end else begin
                     swap_pending_d = swapTexture;
                  end
               end else begin
                  wr_addr_d      = wr_addr_q + ADDR_WIDTH'(TEXELS_PER_BEAT);
                  state_d        = ST_LOAD;
                  swap_pending_d = swap_pending_q | swapTexture;
               end
            end else if (swapTexture || swap_pending_q) begin
               state_d        = ST_SWAP;
               swap_pending_d = 1'b0;
            end
         end

         ST_LOAD: begin
            if (beat_accept && s_axis_tlast) begin
               wr_addr_d = '0;
               // A pulse arriving with the final beat swaps right away rather than lingering as pending.
               if (swap_pending_q || swapTexture) begin
                  state_d        = ST_SWAP;
                  swap_pending_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               if (beat_accept) begin
                  wr_addr_d = wr_addr_q + ADDR_WIDTH'(TEXELS_PER_BEAT);
               end
               swap_pending_d = swap_pending_q | swapTexture;
            end
         end

         ST_SWAP: begin
            state_d        = ST_IDLE;
            swap_pending_d = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The page flips on entry to SWAP so reads sampled at the edge leaving SWAP see the new page.
      if (state_d == ST_SWAP) begin
         front_page_d = ~front_page_q;
      end

      tready_d    = (state_d != ST_SWAP);
      load_busy_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         wr_addr_q      <= '0;
         front_page_q   <= 1'b0;
         swap_pending_q <= 1'b0;
         tready_q       <= 1'b0;
         load_busy_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_addr_q      <= wr_addr_d;
         front_page_q   <= front_page_d;
         swap_pending_q <= swap_pending_d;
         tready_q       <= tready_d;
         load_busy_q    <= load_busy_d;
      end
   end

   assign rd_addr[0] = texelAddr00;
   assign rd_addr[1] = texelAddr01;
   assign rd_addr[2] = texelAddr10;
   assign rd_addr[3] = texelAddr11;

   // One full copy per quad port: every beat lands in all four, each copy has its own read port.
   for (genvar g = 0; g < 4; g++) begin : g_copy
      logic [PIXEL_WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge aclk) begin
         if (beat_accept) begin
            for (int i = 0; i < TEXELS_PER_BEAT; i++) begin
               mem[{~front_page_q, wr_addr_q + ADDR_WIDTH'(i)}] <=
                  s_axis_tdata[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
         end
      end

      assign rd_data[g] = mem[{front_page_q, rd_addr[g]}];
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         texel_d[i] = rd_data[i];
      end
   end

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 4; i++) begin
            texel_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            texel_q[i] <= texel_d[i];
         end
      end
   end

   assign s_axis_tready = tready_q;
   assign swapPending   = swap_pending_q;
   assign loadBusy      = load_busy_q;
   assign frontPage     = front_page_q;
   assign texelOutput00 = texel_q[0];
   assign texelOutput01 = texel_q[1];
   assign texelOutput10 = texel_q[2];
   assign texelOutput11 = texel_q[3];

endmodule

// File: tb/tb_texture_quad_buffer.sv
// Directed bench for texture_quad_buffer: uploads, swaps, quad reads, wrap and reset.
module tb_texture_quad_buffer;

   localparam int AW = 17;
   localparam int PW = 32;
   localparam int SW = 64;

   logic          aclk = 1'b0;
   logic          resetn;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [SW-1:0] s_axis_tdata;
   logic          swapTexture;
   logic          swapPending;
   logic          loadBusy;
   logic          frontPage;
   logic [AW-1:0] texelAddr00, texelAddr01, texelAddr10, texelAddr11;
   logic [PW-1:0] texelOutput00, texelOutput01, texelOutput10, texelOutput11;

   int nCompared   = 0;
   int nMismatched = 0;

   texture_quad_buffer #(
      .STREAM_WIDTH(SW),
      .PIXEL_WIDTH (PW),
      .ADDR_WIDTH  (AW)
   ) dut (
      .aclk         (aclk),
      .resetn       (resetn),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tdata (s_axis_tdata),
      .swapTexture  (swapTexture),
      .swapPending  (swapPending),
      .loadBusy     (loadBusy),
      .frontPage    (frontPage),
      .texelAddr00  (texelAddr00),
      .texelAddr01  (texelAddr01),
      .texelAddr10  (texelAddr10),
      .texelAddr11  (texelAddr11),
      .texelOutput00(texelOutput00),
      .texelOutput01(texelOutput01),
      .texelOutput10(texelOutput10),
      .texelOutput11(texelOutput11)
   );

   always #5 aclk = ~aclk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic last, input logic [SW-1:0] data,
                                input logic swap);
      s_axis_tvalid = valid;
      s_axis_tlast  = last;
      s_axis_tdata  = data;
      swapTexture   = swap;
      tick();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      swapTexture   = 1'b0;
   endtask

   task automatic setQuad(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
      texelAddr00 = a0;
      texelAddr01 = a1;
      texelAddr10 = a2;
      texelAddr11 = a3;
   endtask

   task automatic checkQuad(input string tag, input logic [PW-1:0] e0, input logic [PW-1:0] e1,
                            input logic [PW-1:0] e2, input logic [PW-1:0] e3);
      checkOutput({tag, "_00"}, 64'(texelOutput00), 64'(e0));
      checkOutput({tag, "_01"}, 64'(texelOutput01), 64'(e1));
      checkOutput({tag, "_10"}, 64'(texelOutput10), 64'(e2));
      checkOutput({tag, "_11"}, 64'(texelOutput11), 64'(e3));
   endtask

   // Contents of the page filled by the wrap test: word a holds 0xA0000000+a, except
   // the 65537th beat has overwritten words 0 and 1.
   function automatic logic [PW-1:0] wrapWord(input logic [AW-1:0] a);
      if (a < 2) return 32'hA002_0000 + 32'(a);
      return 32'hA000_0000 + 32'(a);
   endfunction

   initial begin
      logic [PW-1:0] l0, l1;
      logic [AW-1:0] r0, r1, r2, r3;

      resetn        = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = '0;
      swapTexture   = 1'b0;
      setQuad(0, 0, 0, 0);
      #1 resetn = 1'b0;
      tick();
      tick();

      checkQuad("rst_out", 0, 0, 0, 0);
      checkOutput("rst_tready", 64'(s_axis_tready), 0);
      checkOutput("rst_front", 64'(frontPage), 0);
      checkOutput("rst_pending", 64'(swapPending), 0);
      checkOutput("rst_busy", 64'(loadBusy), 0);

      resetn = 1'b1;
      tick();
      checkOutput("rel_tready", 64'(s_axis_tready), 1);
      checkOutput("rel_front", 64'(frontPage), 0);

      // Upload A into page 1, then swap from IDLE.
      applyStimulus(1, 0, {32'h22, 32'h11}, 0);
      checkOutput("a_busy", 64'(loadBusy), 1);
      applyStimulus(1, 0, {32'h44, 32'h33}, 0);
      applyStimulus(1, 0, {32'h66, 32'h55}, 0);
      applyStimulus(1, 1, {32'h88, 32'h77}, 0);
      checkOutput("a_idle_busy", 64'(loadBusy), 0);
      setQuad(0, 1, 2, 3);
      applyStimulus(0, 0, '0, 1);
      checkOutput("a_swap_tready", 64'(s_axis_tready), 0);
      tick();
      checkQuad("a_rd0", 32'h11, 32'h22, 32'h33, 32'h44);
      checkOutput("a_front", 64'(frontPage), 1);
      checkOutput("a_tready", 64'(s_axis_tready), 1);
      setQuad(4, 5, 6, 7);
      tick();
      checkQuad("a_rd4", 32'h55, 32'h66, 32'h77, 32'h88);

      // Swap requested mid-upload of B into page 0.
      applyStimulus(1, 0, {32'hB1, 32'hB0}, 0);
      setQuad(0, 0, 7, 7);
      applyStimulus(0, 0, '0, 1);
      checkOutput("b_pending", 64'(swapPending), 1);
      checkOutput("b_front_hold", 64'(frontPage), 1);
      checkOutput("b_busy", 64'(loadBusy), 1);
      checkQuad("b_old_page", 32'h11, 32'h11, 32'h88, 32'h88);
      applyStimulus(1, 0, {32'hB3, 32'hB2}, 1);
      checkOutput("b_pending2", 64'(swapPending), 1);
      applyStimulus(1, 1, {32'hB5, 32'hB4}, 0);
      checkOutput("b_swap_tready", 64'(s_axis_tready), 0);
      checkOutput("b_swap_pending", 64'(swapPending), 0);
      setQuad(0, 1, 2, 3);
      tick();
      checkOutput("b_front", 64'(frontPage), 0);
      checkOutput("b_tready", 64'(s_axis_tready), 1);
      checkQuad("b_rd0", 32'hB0, 32'hB1, 32'hB2, 32'hB3);
      setQuad(4, 5, 5, 4);
      tick();
      checkQuad("b_rd4", 32'hB4, 32'hB5, 32'hB5, 32'hB4);
      repeat (3) tick();
      checkOutput("b_no_retoggle", 64'(frontPage), 0);

      // Swap pulse coinciding with the tlast beat in LOAD.
      applyStimulus(1, 0, {32'hC1, 32'hC0}, 0);
      applyStimulus(1, 1, {32'hC3, 32'hC2}, 1);
      checkOutput("c_swap_tready", 64'(s_axis_tready), 0);
      setQuad(3, 2, 1, 0);
      tick();
      checkOutput("c_front", 64'(frontPage), 1);
      checkQuad("c_rd", 32'hC3, 32'hC2, 32'hC1, 32'hC0);
      repeat (3) tick();
      checkOutput("c_one_toggle", 64'(frontPage), 1);

      // Swap pulse in IDLE together with a first non-tlast beat becomes pending.
      applyStimulus(1, 0, {32'hD1, 32'hD0}, 1);
      checkOutput("d_pending", 64'(swapPending), 1);
      checkOutput("d_busy", 64'(loadBusy), 1);
      checkOutput("d_front_hold", 64'(frontPage), 1);
      applyStimulus(1, 1, {32'hD3, 32'hD2}, 0);
      setQuad(0, 1, 2, 3);
      tick();
      checkOutput("d_front", 64'(frontPage), 0);
      checkOutput("d_pending_clr", 64'(swapPending), 0);
      checkQuad("d_rd", 32'hD0, 32'hD1, 32'hD2, 32'hD3);

      // Fill page 1 completely plus one beat so the last beat wraps onto words 0 and 1.
      for (int j = 0; j <= 65536; j++) begin
         l0 = 32'hA000_0000 + 32'(2 * j);
         l1 = l0 + 32'd1;
         applyStimulus(1, (j == 65536), {l1, l0}, 0);
      end
      applyStimulus(0, 0, '0, 1);
      setQuad(5, 5, 17'h1FFFF, 0);
      tick();
      checkOutput("w_front", 64'(frontPage), 1);
      checkQuad("w_quad", 32'hA000_0005, 32'hA000_0005, 32'hA001_FFFF, 32'hA002_0000);
      setQuad(1, 2, 0, 3);
      tick();
      checkQuad("w_wrap", 32'hA002_0001, 32'hA000_0002, 32'hA002_0000, 32'hA000_0003);

      for (int n = 0; n < 1000; n++) begin
         r0 = AW'($urandom_range(0, 131071));
         r1 = AW'($urandom_range(0, 131071));
         r2 = AW'($urandom_range(0, 131071));
         r3 = (n % 7 == 0) ? r0 : AW'($urandom_range(0, 131071));
         setQuad(r0, r1, r2, r3);
         tick();
         checkQuad("rand", wrapWord(r0), wrapWord(r1), wrapWord(r2), wrapWord(r3));
      end

      // Reset in the middle of an upload with a swap pending.
      applyStimulus(1, 0, {32'hDEAD_0001, 32'hDEAD_0000}, 0);
      applyStimulus(1, 0, {32'hDEAD_0003, 32'hDEAD_0002}, 1);
      checkOutput("r_pending_pre", 64'(swapPending), 1);
      #3 resetn = 1'b0;
      #1;
      checkOutput("r_async_tready", 64'(s_axis_tready), 0);
      checkOutput("r_async_pending", 64'(swapPending), 0);
      checkOutput("r_async_out", 64'(texelOutput00), 0);
      tick();
      tick();
      resetn = 1'b1;
      tick();
      checkOutput("r_front", 64'(frontPage), 0);
      checkOutput("r_pending", 64'(swapPending), 0);
      checkOutput("r_busy", 64'(loadBusy), 0);
      checkOutput("r_tready", 64'(s_axis_tready), 1);
      applyStimulus(1, 0, {32'hE1, 32'hE0}, 0);
      applyStimulus(1, 1, {32'hE3, 32'hE2}, 0);
      applyStimulus(0, 0, '0, 1);
      setQuad(0, 1, 2, 3);
      tick();
      checkOutput("r_front_new", 64'(frontPage), 1);
      checkQuad("r_rd", 32'hE0, 32'hE1, 32'hE2, 32'hE3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
